quantized_maxpool2d: RTL and testbench
======================================

# quantized_maxpool2d

Streaming 2x2, stride-2 max-pool stage that sits directly downstream of `QuantizedConvReLU2d`. It consumes that block's `conv_result`/`conv_valid` stream (quint8, channel-major raster order) and emits pooled quint8 values in the same channel-major order. The input is post-ReLU with a single per-tensor scale and zero point, so the max of the quantized codes equals the quantized max. No requantization is needed.

## Interface
Parameters:
- `CHANNELS`, 128: channels per frame.
- `IN_WIDTH`, 28: input columns per channel.
- `IN_HEIGHT`, 28: input rows per channel.
- Derived: `OUT_WIDTH = IN_WIDTH/2` (floor), `OUT_HEIGHT = IN_HEIGHT/2` (floor).

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: one-cycle pulse; begins a new frame and clears all counters and flags.
- `in_data`  in  8: unsigned quint8 pixel; connects to `conv_result`.
- `in_valid`  in  1: pixel qualifier; connects to `conv_valid`. No backpressure.
- `pool_result`  out  8: pooled value.
- `pool_valid`  out  1: qualifies `pool_result`.
- `busy`  out  1: high from `start` until the final output is emitted.
- `done`  out  1: one-cycle pulse, coincident with the final `pool_valid` of the frame.
- `overrun`  out  1: sticky; a beat arrived while not busy.

## Operation
- Input order: index = ch*IN_HEIGHT*IN_WIDTH + r*IN_WIDTH + c. The block keeps counters `c`, `r` and `ch`, advancing one step per accepted beat (`in_valid && busy`).
  - `c` wraps to 0 at IN_WIDTH-1 and increments `r`.
  - `r` wraps at IN_HEIGHT-1 and increments `ch`.
  - Accepting the last beat of the last channel ends the frame: `busy` falls.
- Data path:
  - Even `c`: latch `in_data` into hold register `h`.
  - Odd `c`: compute `m = max(h, in_data)`.
  - Even `r`: write `m` to line buffer `lb[c>>1]`. Depth is OUT_WIDTH entries, 8 bits each.
  - Odd `r`: emit `max(lb[c>>1], m)`.
- Odd dimensions (floor mode):
  - If IN_WIDTH is odd, the last column is consumed by the counters but never latched or written.
  - If IN_HEIGHT is odd, the last row is consumed but never written and never emits.
- Output count per frame: exactly CHANNELS*OUT_HEIGHT*OUT_WIDTH.
- Comparison is unsigned. Ties give the equal value; 255 passes through unchanged.
- The line buffer is never cleared. Each even row fully rewrites every entry before the odd row reads it.
- `start`:
  - Resets `c`, `r`, `ch` and clears `overrun`; sets `busy`.
  - If `in_valid` is high in the same cycle, that beat is accepted as pixel (ch0, r0, c0).
  - `start` during a busy frame aborts it: partial windows are discarded and no `done` is issued for the aborted frame.
- `in_valid` while `busy` = 0: the beat is ignored, `overrun` is set to 1, counters hold and no output is produced.
- State: IDLE (`busy`=0) and RUN (`busy`=1).
  - IDLE→RUN on `start`.
  - RUN→IDLE on acceptance of the last beat.
  - RUN→RUN on `start` (restart).

## Timing
- Reset values: `pool_result`=0, `pool_valid`=0, `busy`=0, `done`=0, `overrun`=0; all counters and `h` = 0.
- Latency: `pool_valid` is high exactly one cycle after the rising edge that samples the completing beat (odd `r`, odd `c`, inside the pooled region). `pool_result` is registered.
- `pool_valid` lasts one cycle per output; back-to-back outputs cannot occur, since at least 2 beats separate consecutive window completions.
- `done` asserts in the same cycle as the frame's last `pool_valid`.
- `busy` falls in the cycle after the last beat is accepted.
  - When that beat completes a window, `busy` falls in the same cycle `done` rises.
  - With odd dimensions, the final window completes earlier, so `done` precedes the fall of `busy`.
- Arbitrary gaps in `in_valid` are allowed; outputs are unchanged apart from timing.
- `rst` mid-frame: all outputs return to their reset values on the next edge. The next valid result requires a new `start`.

## Test plan
- IN_WIDTH=IN_HEIGHT=4, CHANNELS=2; `start`, then 32 back-to-back beats with value = index.
  - Required outputs: 5, 7, 13, 15, 21, 23, 29, 31.
  - First `pool_valid` one cycle after beat 5 is sampled; `done` with the 8th output; `busy`=0 afterwards.
- Same stimulus with random 0-3 cycle gaps between beats → identical output sequence, `done` on the 8th output.
- IN_WIDTH=IN_HEIGHT=5, CHANNELS=1; values = index 0..24 → outputs 6, 8, 16, 18 only (4 outputs). `done` on output 4; `busy` falls after beat 24.
- Reversed ramp (255 down to 224) with the 4x4x2 configuration, plus a frame of all 255 → maxima correct and 255 preserved.
- Abort and reset:
  - After 10 beats, pulse `start` with a simultaneous beat → that beat is taken as pixel 0, and the next 32-beat ramp frame yields the 8 correct outputs.
  - Repeat with `rst` instead of `start` → no outputs until `start`.
- After `done`, one extra beat → `overrun`=1, no `pool_valid`; a following `start` clears `overrun`.

Source files
------------

// File: rtl/quantized_maxpool2d.sv
// ---------------------------------------------------------------------------
// quantized_maxpool2d
//   Streaming 2x2 / stride-2 max-pool over a channel-major quint8 raster.
//   Inputs are post-ReLU codes sharing one scale/zero point, so the max of
//   the codes is the quantized max and no requantization is performed.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        one-cycle pulse: begin (or restart) a frame
//   in_data      quint8 pixel
//   in_valid     pixel qualifier
//   pool_result  pooled quint8 value (registered)
//   pool_valid   qualifies pool_result, one cycle per output
//   busy         high while a frame is being consumed
//   done         one-cycle pulse with the final pool_valid of a frame
//   overrun      sticky: a beat arrived while not busy
//
// Handshake: in_valid has no ready; a beat is accepted in any cycle where
// in_valid && (busy || start). pool_valid is a one-cycle strobe with no
// backpressure; pool_result is only meaningful while pool_valid is high.
// ---------------------------------------------------------------------------
module quantized_maxpool2d #(
  parameter int CHANNELS  = 128,
  parameter int IN_WIDTH  = 28,
  parameter int IN_HEIGHT = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] pool_result,
  output logic       pool_valid,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int OUT_WIDTH  = IN_WIDTH / 2;
  localparam int OUT_HEIGHT = IN_HEIGHT / 2;

  localparam int CW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int RW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int HW = (CHANNELS  > 1) ? $clog2(CHANNELS)  : 1;
  localparam int LW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  localparam logic [CW-1:0] C_LAST      = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST      = RW'(IN_HEIGHT - 1);
  localparam logic [HW-1:0] CH_LAST     = HW'(CHANNELS - 1);
  // Last column/row that belongs to a pooled window (floor mode).
  localparam logic [CW-1:0] C_POOL_LAST = CW'(2 * OUT_WIDTH - 1);
  localparam logic [RW-1:0] R_POOL_LAST = RW'(2 * OUT_HEIGHT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [HW-1:0] ch;
  logic [7:0]    h;
  logic [7:0]    lb [OUT_WIDTH];

  // Position of the beat presented this cycle; start forces it to (0,0,0)
  // so a beat coincident with start is taken as the first pixel.
  logic          accept;
  logic [CW-1:0] cur_c;
  logic [RW-1:0] cur_r;
  logic [HW-1:0] cur_ch;
  logic          col_in;
  logic          row_in;
  logic [LW-1:0] lb_idx;
  logic [7:0]    pair_max;
  logic [7:0]    lb_rd;
  logic [7:0]    win_max;
  logic          last_col;
  logic          last_row;
  logic          last_ch;
  logic          completes;
  logic          final_win;
  logic          frame_end;

  assign busy = (state == S_RUN);

  always_comb begin
    accept    = in_valid && (busy || start);
    cur_c     = start ? '0 : c;
    cur_r     = start ? '0 : r;
    cur_ch    = start ? '0 : ch;
    col_in    = (cur_c <= C_POOL_LAST);
    row_in    = (cur_r <= R_POOL_LAST);
    lb_idx    = LW'(cur_c >> 1);
    pair_max  = (in_data > h) ? in_data : h;
    lb_rd     = lb[lb_idx];
    win_max   = (lb_rd > pair_max) ? lb_rd : pair_max;
    last_col  = (cur_c == C_LAST);
    last_row  = (cur_r == R_LAST);
    last_ch   = (cur_ch == CH_LAST);
    completes = accept && col_in && row_in && cur_c[0] && cur_r[0];
    final_win = last_ch && (cur_c == C_POOL_LAST) && (cur_r == R_POOL_LAST);
    frame_end = accept && last_col && last_row && last_ch;
  end

  // Control, counters, hold register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      c           <= '0;
      r           <= '0;
      ch          <= '0;
      h           <= '0;
      pool_result <= '0;
      pool_valid  <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      pool_valid <= completes;
      done       <= completes && final_win;
      if (completes) begin
        pool_result <= win_max;
      end

      if (start) begin
        overrun <= 1'b0;
      end else if (in_valid && !busy) begin
        overrun <= 1'b1;
      end

      // Ending the frame wins over start so a one-beat frame still ends.
      if (frame_end) begin
        state <= S_IDLE;
      end else if (start) begin
        state <= S_RUN;
      end

      if (accept) begin
        if (last_col) begin
          c <= '0;
          if (last_row) begin
            r  <= '0;
            ch <= last_ch ? '0 : cur_ch + 1'b1;
          end else begin
            r  <= cur_r + 1'b1;
            ch <= cur_ch;
          end
        end else begin
          c  <= cur_c + 1'b1;
          r  <= cur_r;
          ch <= cur_ch;
        end
      end else if (start) begin
        c  <= '0;
        r  <= '0;
        ch <= '0;
      end

      // Even column of a pooled pair: remember the left pixel.
      if (accept && col_in && !cur_c[0]) begin
        h <= in_data;
      end
    end
  end

  // Line buffer holds the even-row pair maxima. It is never cleared: every
  // even row rewrites all entries before the following odd row reads them.
  always_ff @(posedge clk) begin
    if (accept && col_in && row_in && cur_c[0] && !cur_r[0]) begin
      lb[lb_idx] <= pair_max;
    end
  end

endmodule

// File: tb/tb_quantized_maxpool2d.sv
// ---------------------------------------------------------------------------
// tb_quantized_maxpool2d
//   Two instances: dut_a (4x4, 2 channels, even dims) and dut_b (5x5,
//   1 channel, odd dims). Expected outputs are computed from the pixel
//   array as 2x2 window maxima and queued; per-instance monitors pop and
//   compare whenever pool_valid is seen.
// ---------------------------------------------------------------------------
module tb_quantized_maxpool2d;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       start_a, valid_a, start_b, valid_b;
  logic [7:0] res_a, res_b;
  logic       pv_a, pv_b, busy_a, busy_b, done_a, done_b, ovr_a, ovr_b;

  always #5 clk = ~clk;

  quantized_maxpool2d #(.CHANNELS(2), .IN_WIDTH(4), .IN_HEIGHT(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_data(in_data),
    .in_valid(valid_a), .pool_result(res_a), .pool_valid(pv_a),
    .busy(busy_a), .done(done_a), .overrun(ovr_a)
  );

  quantized_maxpool2d #(.CHANNELS(1), .IN_WIDTH(5), .IN_HEIGHT(5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_data(in_data),
    .in_valid(valid_b), .pool_result(res_b), .pool_valid(pv_b),
    .busy(busy_b), .done(done_b), .overrun(ovr_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int first_pv_cyc_a = -1;
  int lat_beat_cyc   = -2;

  // {last_of_frame, value}
  logic [8:0] exp_q_a[$];
  logic [8:0] exp_q_b[$];
  logic [8:0] e_a, e_b;
  logic [7:0] pix[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (pv_a) begin
        if (first_pv_cyc_a < 0) first_pv_cyc_a = cyc;
        if (exp_q_a.size() == 0) check("a_unexpected_output", int'(res_a), -1);
        else begin
          e_a = exp_q_a.pop_front();
          check("a_pool_result", int'(res_a), int'(e_a[7:0]));
          check("a_done_flag", int'(done_a), int'(e_a[8]));
        end
      end else if (done_a) check("a_done_without_valid", 1, 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pv_b) begin
        if (exp_q_b.size() == 0) check("b_unexpected_output", int'(res_b), -1);
        else begin
          e_b = exp_q_b.pop_front();
          check("b_pool_result", int'(res_b), int'(e_b[7:0]));
          check("b_done_flag", int'(done_b), int'(e_b[8]));
        end
      end else if (done_b) check("b_done_without_valid", 1, 0);
    end
  end

  // ---------------- reference model ----------------
  // Window (ch,oy,ox) completes at its bottom-right pixel; it is expected
  // only if that pixel is among the first n beats sent.
  task automatic push_expected(input int sel, input int nch, input int hh,
                               input int ww, input int n);
    int oh, ow, base, last_idx, idx;
    logic [7:0] v;
    logic [8:0] item;
    oh = hh / 2;
    ow = ww / 2;
    for (int ch = 0; ch < nch; ch++)
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          base     = ch * hh * ww;
          last_idx = base + (2 * oy + 1) * ww + 2 * ox + 1;
          if (last_idx < n) begin
            v = 8'd0;
            for (int dy = 0; dy < 2; dy++)
              for (int dx = 0; dx < 2; dx++) begin
                idx = base + (2 * oy + dy) * ww + 2 * ox + dx;
                if (pix[idx] > v) v = pix[idx];
              end
            item = {(ch == nch - 1 && oy == oh - 1 && ox == ow - 1), v};
            if (sel == 0) exp_q_a.push_back(item);
            else exp_q_b.push_back(item);
          end
        end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input int sel, input logic v, input logic s);
    if (sel == 0) begin valid_a = v; start_a = s; end
    else begin valid_b = v; start_b = s; end
  endtask

  task automatic fill_ramp(input int n, input int first, input int step);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(8'(first + step * i));
  endtask

  task automatic fill_const(input int n, input logic [7:0] v);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(v);
  endtask

  task automatic fill_rand(input int n);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk); set_in(sel, 1'b0, 1'b1);
    @(negedge clk); set_in(sel, 1'b0, 1'b0);
  endtask

  // Drives pix[first .. first+n-1]; returns at the negedge after the last
  // beat was sampled.
  task automatic run_beats(input int sel, input int first, input int n,
                           input logic with_start, input int max_gap);
    int g;
    for (int i = first; i < first + n; i++) begin
      g = $urandom_range(max_gap, 0);
      repeat (g) begin @(negedge clk); set_in(sel, 1'b0, 1'b0); end
      @(negedge clk);
      in_data = pix[i];
      set_in(sel, 1'b1, (i == first) && with_start);
      if (sel == 0 && i == 5) lat_beat_cyc = cyc + 1;
    end
    @(negedge clk); set_in(sel, 1'b0, 1'b0);
  endtask

  task automatic frame_a(input int max_gap);
    pulse_start(0);
    check("a_busy_after_start", int'(busy_a), 1);
    push_expected(0, 2, 4, 4, 32);
    run_beats(0, 0, 32, 1'b0, max_gap);
    check("a_busy_after_frame", int'(busy_a), 0);
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1'b1; in_data = 8'd0;
    start_a = 1'b0; valid_a = 1'b0; start_b = 1'b0; valid_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pool_result", int'(res_a), 0);
    check("rst_pool_valid", int'(pv_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_overrun", int'(ovr_a), 0);
    check("rst_b_busy", int'(busy_b), 0);
    rst = 1'b0;

    // Ramp back-to-back, with first-output latency.
    fill_ramp(32, 0, 1);
    first_pv_cyc_a = -1;
    frame_a(0);
    check("a_first_valid_latency", first_pv_cyc_a, lat_beat_cyc);

    // Ramp with random gaps.
    frame_a(3);

    // Reversed ramp and saturated frame.
    fill_ramp(32, 255, -1);
    frame_a(0);
    fill_const(32, 8'd255);
    frame_a(1);

    // Random frames.
    for (int k = 0; k < 3; k++) begin
      fill_rand(32);
      frame_a(3);
    end

    // Odd dimensions: done precedes busy falling after beat 24.
    fill_ramp(25, 0, 1);
    pulse_start(1);
    push_expected(1, 1, 5, 5, 25);
    run_beats(1, 0, 24, 1'b0, 0);
    check("b_busy_before_last_beat", int'(busy_b), 1);
    run_beats(1, 24, 1, 1'b0, 0);
    check("b_busy_after_last_beat", int'(busy_b), 0);
    for (int k = 0; k < 2; k++) begin
      fill_rand(25);
      pulse_start(1);
      push_expected(1, 1, 5, 5, 25);
      run_beats(1, 0, 25, 1'b0, 3);
      check("b_busy_after_rand_frame", int'(busy_b), 0);
    end

    // Abort by start with a coincident beat.
    fill_ramp(32, 0, 1);
    pulse_start(0);
    push_expected(0, 2, 4, 4, 10);
    run_beats(0, 0, 10, 1'b0, 0);
    push_expected(0, 2, 4, 4, 32);
    run_beats(0, 0, 32, 1'b1, 0);
    check("a_busy_after_restart_frame", int'(busy_a), 0);

    // Abort by reset: stray beats afterwards produce nothing.
    pulse_start(0);
    push_expected(0, 2, 4, 4, 10);
    run_beats(0, 0, 10, 1'b0, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("a_busy_after_rst", int'(busy_a), 0);
    check("a_valid_after_rst", int'(pv_a), 0);
    run_beats(0, 0, 3, 1'b0, 0);
    check("a_overrun_stray_beats", int'(ovr_a), 1);
    check("a_busy_stray_beats", int'(busy_a), 0);
    frame_a(0);

    // Overrun after done, cleared by start.
    run_beats(0, 0, 1, 1'b0, 0);
    check("a_overrun_set", int'(ovr_a), 1);
    pulse_start(0);
    check("a_overrun_cleared", int'(ovr_a), 0);
    check("a_busy_after_clear", int'(busy_a), 1);
    push_expected(0, 2, 4, 4, 32);
    run_beats(0, 0, 32, 1'b0, 0);

    repeat (5) @(negedge clk);
    check("a_expected_queue_empty", exp_q_a.size(), 0);
    check("b_expected_queue_empty", exp_q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d, required finish earlier", cyc);
    $fatal(1, "timeout");
  end

endmodule
